// File: rtl/slurm16_mem_responder.sv
// SLURM16 CPU-to-SRAM memory responder.
// Accepts one CPU request at a time, presents it on a registered SRAM port for
// WAIT_STATES+1 cycles, and returns read data on memory_in. Back-to-back
// requests are accepted in the last access cycle, so there is no idle gap.
// Optional write protection of low memory is enabled with the macro
// SLURM16_MEM_RESP_WRITE_PROTECT_EN.
module slurm16_mem_responder #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] PROTECT_TOP = 16'h0100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] memory_address,
  input  logic [15:0] memory_out,
  input  logic        memory_valid,
  input  logic        memory_wr,
  input  logic [1:0]  memory_wr_mask,
  output logic        memory_ready,
  output logic [15:0] memory_in,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic [1:0]  sram_be,
  output logic        sram_ce,
  output logic        sram_we,
  input  logic [15:0] sram_rdata,
  output logic        wp_violation
);

`ifdef SLURM16_MEM_RESP_WRITE_PROTECT_EN
  localparam bit ProtEn = 1'b1;
`else
  localparam bit ProtEn = 1'b0;
`endif

  // Value loaded into the wait counter on entry to the wait state.
  localparam logic [2:0] WaitLoad = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q;
  logic        acc_wr_q;
  logic        last;
  logic        accept;
  logic        in_region;
  logic        prot;

  assign last = ((state_q == StAccess) && (WAIT_STATES == 0)) ||
                ((state_q == StWait) && (cnt_q == 3'd0));
  assign accept    = memory_valid & memory_ready;
  assign in_region = (memory_address < PROTECT_TOP);
  // Protected writes still complete on the bus timing-wise, but never strobe SRAM.
  assign prot      = ProtEn & memory_wr & in_region;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: restart at StAccess whenever a request is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StAccess;
      end
      StAccess: begin
        if (WAIT_STATES == 0) state_d = accept ? StAccess : StIdle;
        else                  state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 3'd0) state_d = accept ? StAccess : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: ready when idle or finishing the current access.
  always_comb begin
    memory_ready = 1'b0;
    if ((state_q == StIdle) || last) memory_ready = 1'b1;
  end

  // Wait counter: loaded only on entry to StWait, counts down to zero, never wraps.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= 3'd0;
    end else if ((state_q == StAccess) && (state_d == StWait)) begin
      cnt_q <= WaitLoad;
    end else if ((state_q == StWait) && (cnt_q != 3'd0)) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  // SRAM port, read-data return and sticky protection flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sram_addr    <= 16'h0000;
      sram_wdata   <= 16'h0000;
      sram_be      <= 2'b00;
      sram_ce      <= 1'b0;
      sram_we      <= 1'b0;
      acc_wr_q     <= 1'b0;
      memory_in    <= 16'h0000;
      wp_violation <= 1'b0;
    end else begin
      // Capture read data before a back-to-back accept overwrites acc_wr_q.
      if (last && !acc_wr_q) memory_in <= sram_rdata;
      if (accept) begin
        sram_addr  <= memory_address;
        sram_wdata <= memory_out;
        sram_we    <= memory_wr & ~prot;
        sram_be    <= memory_wr ? (prot ? 2'b00 : memory_wr_mask) : 2'b11;
        sram_ce    <= 1'b1;
        acc_wr_q   <= memory_wr;
        if (prot) wp_violation <= 1'b1;
      end else if (last) begin
        sram_ce <= 1'b0;
      end
    end
  end

endmodule
